stream_out_serializer: RTL and testbench
========================================

# stream_out_serializer

Parametrised output-capture block for the board-level kernel wrapper: accepts NUM_CH ap_fifo-style write streams from the HLS kernel and buffers each in a per-channel FIFO. Buffered words are serialised round-robin onto a narrow, pin-limited data_out/data_valid bus as framed packets. It generalises the fixed 4-channel, 4-bit capture path to any channel count, word width, output width and buffer depth. It adds backpressure, overflow flags and a running parity probe.

## Interface
- NUM_CH, 4, number of input streams; 1..2^OUT_W
- DATA_W, 32, input word width; must be a multiple of OUT_W
- OUT_W, 4, output bus width; ≥ 1
- FIFO_DEPTH, 16, words per channel FIFO; power of two, ≥ 2
- BEATS (derived), DATA_W/OUT_W, data beats per frame
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  reset; asynchronous, active-high
- ch_din  in  NUM_CH*DATA_W  channel c word at bits [c*DATA_W +: DATA_W]
- ch_write  in  NUM_CH  write strobe per channel
- ch_full_n  out  NUM_CH  1 = channel can accept a word; combinational from registered count
- data_out  out  OUT_W  serial beat, registered
- data_valid  out  1  data_out carries a beat this cycle, registered
- probe_out  out  1  running XOR of all bits of every beat emitted since reset, registered
- ovf_err  out  NUM_CH  sticky: a write arrived while ch_full_n was 0

## Operation
- Reset, asynchronous: all FIFOs empty; ch_full_n all 1; data_out 0; data_valid 0; probe_out 0; ovf_err 0; FSM to IDLE; round-robin pointer to channel 0.
- Write acceptance:
  - ch_write[c]=1 with ch_full_n[c]=1 pushes ch_din slice c at the rising edge.
  - ch_write[c]=1 with ch_full_n[c]=0 drops the word and sets ovf_err[c].
  - ch_full_n[c]=0 exactly when count==FIFO_DEPTH.
- Frame format: 1 header beat, then BEATS data beats. The header beat is the channel index, zero-extended to OUT_W. Data beats are sent MSB slice first.
- FSM states:
  - IDLE: if any FIFO is non-empty, select the first non-empty channel at or after the RR pointer (wrapping). On the same edge: pop its head word into the shift register, drive the header, set data_valid=1, move the RR pointer to selected+1 mod NUM_CH, and go to DATA.
  - DATA: shift one OUT_W slice per cycle, beat counter 0..BEATS-1. After the last beat, if any FIFO is non-empty, perform the IDLE selection on that same edge, so the next header follows with no gap. Otherwise go to IDLE with data_valid=0 and data_out=0.
- Push and pop on the same channel at the same edge: both take effect; count is unchanged.
- probe_out updates on every edge at which a beat is registered: probe_out ^= XOR-reduce(beat).
- ovf_err is cleared only by reset.

## Timing
- Minimum latency: word pushed at edge k into empty FIFOs with FSM in IDLE → header visible after edge k+1, data beats after edges k+2..k+1+BEATS.
- Frame length: 1+BEATS cycles with data_valid continuously high. Back-to-back frames have zero idle cycles.
- Frame occupancy: the FIFO slot frees at the header edge. ch_full_n rises in the cycle after that edge.
- Throughput: one word per 1+BEATS cycles, shared across all channels. Sustained input above this rate fills the FIFOs and deasserts full_n.
- Reset mid-frame: outputs return to reset values immediately. No residual beats appear after release, and partial frames are discarded.

## Test plan
- Single word: defaults, ch2 writes 0xDEADBEEF once, all else idle.
  - Required: 9 valid cycles with beats 2,D,E,A,D,B,E,E,F, then data_valid=0.
  - Required: probe_out equals the XOR of those bits (=1).
- Round-robin: channels 0-3 write 0x00000000, 0x11111111, 0x22222222, 0x33333333 on the same edge.
  - Required: headers 0,1,2,3 in order.
  - Required: 36 contiguous valid cycles, no gaps.
- Fairness: ch0 streams continuously and ch3 writes one word mid-stream.
  - Required: ch3's frame appears immediately after ch0's current frame.
  - Required: ch0 then resumes.
- Overflow: ch1 writes 0x00000000..0x00000013 on 20 consecutive edges.
  - Required: ch1_full_n drops when count hits 16.
  - Required: dropped words are absent, ovf_err[1]=1, and other ovf_err bits stay 0.
  - Required: accepted words are emitted in order.
- Reset mid-frame: ap_rst pulses during data beat 3 of a ch0 frame, with 5 words queued.
  - Required: data_valid goes to 0 asynchronously and ch_full_n is all 1.
  - Required: no beats after release until new writes arrive.
- Parameter sweep: NUM_CH=3, DATA_W=16, OUT_W=8, FIFO_DEPTH=4; ch1 writes 0xABCD.
  - Required: beats 0x01, 0xAB, 0xCD.
  - Required: full_n drops after 4 unread words.

Source files
------------

// File: rtl/stream_out_serializer.sv
// stream_out_serializer: per-channel FIFOs drained round-robin onto a narrow framed beat bus
module stream_out_serializer #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    input  logic [NUM_CH-1:0]        ch_write,
    output logic [NUM_CH-1:0]        ch_full_n,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_valid,
    output logic                     probe_out,
    output logic [NUM_CH-1:0]        ovf_err
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = $clog2(BEATS + 1);

    typedef enum logic {IDLE, DATA} state_t;

    logic [DATA_W-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [NUM_CH];
    logic [AW-1:0]     rd_ptr [NUM_CH];
    logic [AW:0]       count [NUM_CH];
    logic [NUM_CH-1:0] push, pop, ne;
    state_t            state;
    logic [CW-1:0]     rr, sel, idx, rr_nx;
    logic              avail, sending, take;
    logic [BW-1:0]     beat_cnt;
    logic [DATA_W-1:0] shreg, head;
    logic [OUT_W-1:0]  hdr, slice;

    // Full/empty flags come straight from the registered occupancy counts
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_full_n[c] = count[c] != (AW+1)'(FIFO_DEPTH);
            ne[c]        = count[c] != '0;
        end
    end

    assign push = ch_write & ch_full_n;

    // First non-empty channel at or after the round-robin pointer; lowest offset wins
    always_comb begin
        sel   = '0;
        avail = 1'b0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CW'((int'(rr) + i) % NUM_CH);
            if (ne[idx]) begin
                sel   = idx;
                avail = 1'b1;
            end
        end
    end

    // A new frame starts whenever no data beat is pending and some channel has a word
    always_comb begin
        sending = state == DATA && beat_cnt != BW'(BEATS);
        take    = !sending && avail;
        pop     = '0;
        if (take) pop[sel] = 1'b1;
    end

    assign head  = mem[sel][rd_ptr[sel]];
    assign hdr   = OUT_W'(sel);
    assign slice = shreg[DATA_W-1 -: OUT_W];
    assign rr_nx = sel == CW'(NUM_CH - 1) ? '0 : sel + 1'b1;

    // FIFO storage needs no reset; validity is tracked by the pointers and counts
    always_ff @(posedge ap_clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push[c]) mem[c][wr_ptr[c]] <= ch_din[c*DATA_W +: DATA_W];
    end

    // Pointer/count bookkeeping and sticky overflow flags per channel
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            ovf_err <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] != pop[c]) count[c] <= push[c] ? count[c] + 1'b1 : count[c] - 1'b1;
                if (ch_write[c] && !ch_full_n[c]) ovf_err[c] <= 1'b1;
            end
        end
    end

    // Frame FSM: header beat on pop, then MSB-first slices, chaining straight into the next frame
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE;
            rr         <= '0;
            beat_cnt   <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            probe_out  <= 1'b0;
        end else if (sending) begin
            data_out   <= slice;
            shreg      <= shreg << OUT_W;
            beat_cnt   <= beat_cnt + 1'b1;
            data_valid <= 1'b1;
            probe_out  <= probe_out ^ (^slice);
        end else if (avail) begin
            state      <= DATA;
            rr         <= rr_nx;
            beat_cnt   <= '0;
            shreg      <= head;
            data_out   <= hdr;
            data_valid <= 1'b1;
            probe_out  <= probe_out ^ (^hdr);
        end else begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_out_serializer.sv
// tb_stream_out_serializer: directed checks of framing, round-robin, overflow, reset and a second parameter set
module tb_stream_out_serializer;
    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic [127:0] ch_din = '0;
    logic [3:0]   ch_write = '0;
    logic [3:0]   ch_full_n, ovf_err, data_out;
    logic         data_valid, probe_out;
    logic [47:0]  din2 = '0;
    logic [2:0]   wr2 = '0;
    logic [2:0]   full2, ovf2;
    logic [7:0]   out2;
    logic         valid2, probe2;

    int    n_chk = 0;
    int    n_fail = 0;
    int    q[$];
    int    q2[$];
    logic  pr1 = 1'b0;
    logic  pr2 = 1'b0;
    string ph = "init";

    stream_out_serializer dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ch_din(ch_din), .ch_write(ch_write),
        .ch_full_n(ch_full_n), .data_out(data_out), .data_valid(data_valid),
        .probe_out(probe_out), .ovf_err(ovf_err)
    );

    stream_out_serializer #(.NUM_CH(3), .DATA_W(16), .OUT_W(8), .FIFO_DEPTH(4)) dut2 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ch_din(din2), .ch_write(wr2),
        .ch_full_n(full2), .data_out(out2), .data_valid(valid2),
        .probe_out(probe2), .ovf_err(ovf2)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0h expected %0h", ph, tag, got, exp);
        end
    endtask

    task automatic add_frame(int ch, logic [31:0] w);
        q.push_back(ch);
        for (int b = 7; b >= 0; b--) q.push_back(int'(w[b*4 +: 4]));
    endtask

    task automatic add_frame2(int ch, logic [15:0] w);
        q2.push_back(ch);
        q2.push_back(int'(w[15:8]));
        q2.push_back(int'(w[7:0]));
    endtask

    task automatic cyc();
        int         e, f;
        logic [3:0] ev;
        logic [7:0] fv;
        @(negedge ap_clk);
        e = -1;
        f = -1;
        if (q.size() > 0) e = q.pop_front();
        if (q2.size() > 0) f = q2.pop_front();
        ev = e >= 0 ? 4'(e) : 4'h0;
        fv = f >= 0 ? 8'(f) : 8'h00;
        if (e >= 0) pr1 = pr1 ^ (^ev);
        if (f >= 0) pr2 = pr2 ^ (^fv);
        chk("valid", data_valid, e >= 0);
        chk("data", data_out, ev);
        chk("probe", probe_out, pr1);
        chk("valid2", valid2, f >= 0);
        chk("data2", out2, fv);
        chk("probe2", probe2, pr2);
    endtask

    task automatic drain();
        while (q.size() > 0 || q2.size() > 0) cyc();
        cyc();
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst   = 1'b1;
        ch_write = '0;
        wr2      = '0;
        #1;
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_probe", probe_out, 0);
        chk("rst_full_n", ch_full_n, 4'hF);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_valid2", valid2, 0);
        chk("rst_full_n2", full2, 3'b111);
        chk("rst_ovf2", ovf2, 0);
        q.delete();
        q2.delete();
        pr1 = 1'b0;
        pr2 = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    initial begin
        ph = "reset";
        do_reset();

        ph = "single";
        q.push_back(-1);
        add_frame(2, 32'hDEADBEEF);
        ch_din[95:64] = 32'hDEADBEEF;
        ch_write = 4'b0100;
        cyc();
        ch_write = '0;
        drain();
        chk("probe_final", probe_out, 1);

        ph = "rr";
        do_reset();
        q.push_back(-1);
        add_frame(0, 32'h00000000);
        add_frame(1, 32'h11111111);
        add_frame(2, 32'h22222222);
        add_frame(3, 32'h33333333);
        ch_din = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        ch_write = 4'b1111;
        cyc();
        ch_write = '0;
        drain();
        chk("probe_final", probe_out, 0);

        ph = "fair";
        do_reset();
        q.push_back(-1);
        add_frame(0, 32'h01234567);
        add_frame(3, 32'hCAFEF00D);
        add_frame(0, 32'h89ABCDEF);
        add_frame(0, 32'h0F0F0F0F);
        ch_din[31:0] = 32'h01234567;
        ch_write = 4'b0001;
        cyc();
        ch_din[31:0] = 32'h89ABCDEF;
        cyc();
        ch_din[31:0] = 32'h0F0F0F0F;
        cyc();
        ch_din[127:96] = 32'hCAFEF00D;
        ch_write = 4'b1000;
        cyc();
        ch_write = '0;
        drain();
        chk("ovf", ovf_err, 0);

        ph = "ovf";
        do_reset();
        q.push_back(-1);
        for (int j = 0; j < 18; j++) add_frame(1, 32'(j));
        for (int j = 0; j < 20; j++) begin
            ch_din[63:32] = 32'(j);
            ch_write = 4'b0010;
            cyc();
            chk("full_n", ch_full_n, (j == 17 || j == 18) ? 4'b1101 : 4'b1111);
            chk("ovf_live", ovf_err, j >= 18 ? 4'b0010 : 4'b0000);
        end
        ch_write = '0;
        drain();
        chk("ovf_final", ovf_err, 4'b0010);

        ph = "midrst";
        do_reset();
        q.push_back(-1);
        add_frame(0, 32'h76543210);
        ch_write = 4'b0001;
        for (int j = 0; j < 4; j++) begin
            ch_din[31:0] = 32'h76543210 + 32'(j);
            cyc();
        end
        ch_din[31:0] = 32'h76543214;
        chk("pre_rst_valid", data_valid, 1);
        do_reset();
        for (int j = 0; j < 20; j++) cyc();
        ph = "midrst_new";
        q.push_back(-1);
        add_frame(2, 32'h5A5A1234);
        ch_din[95:64] = 32'h5A5A1234;
        ch_write = 4'b0100;
        cyc();
        ch_write = '0;
        drain();

        ph = "sweep";
        do_reset();
        q2.push_back(-1);
        add_frame2(1, 16'hABCD);
        din2[31:16] = 16'hABCD;
        wr2 = 3'b010;
        cyc();
        wr2 = '0;
        drain();
        ph = "sweep_fill";
        q2.push_back(-1);
        for (int j = 0; j < 6; j++) add_frame2(1, 16'h1000 + 16'(j));
        for (int j = 0; j < 6; j++) begin
            din2[31:16] = 16'h1000 + 16'(j);
            wr2 = 3'b010;
            cyc();
            chk("full_n2", full2, j == 5 ? 3'b101 : 3'b111);
        end
        wr2 = '0;
        drain();
        chk("ovf2", ovf2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
